// File: rtl/acoustic_burst_gen.sv
// Multi-channel acoustic burst generator.
// Each channel emits burst_len square-wave periods (half_period high, half_period
// low) starting k*stagger cycles after channel 0. Single-shot mode returns to
// idle with a done pulse; continuous mode repeats after gap_len idle cycles.
module acoustic_burst_gen #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] stagger,
  output logic [N_CH-1:0]  sig_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_count
);

  // Time/offset width: up to 15 staggers must fit without wrapping.
  localparam int T_W = CNT_W + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;

  // Configuration latched at acceptance
  logic               r_mode;
  logic [DIV_W-1:0]   r_hp;
  logic [CNT_W-1:0]   r_bl;
  logic [CNT_W-1:0]   r_gap;
  logic [CNT_W-1:0]   r_stg;

  // Sequence counters
  logic [T_W-1:0]     r_t;        // burst cycle number produced at the next edge
  logic [CNT_W-1:0]   r_gap_cnt;  // gap cycles already produced

  // Per-channel waveform state
  logic [N_CH-1:0]    r_run;      // channel currently emitting
  logic [N_CH-1:0]    r_fin;      // channel finished for this burst
  logic [N_CH-1:0]    r_sig;
  logic [DIV_W-1:0]   r_hcnt [N_CH];  // cycles spent in current half-period (1..hp)
  logic [CNT_W:0]     r_hnum [N_CH];  // half-periods completed

  // Registered status outputs
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_count;

  // Combinational helpers
  logic [T_W-1:0]     w_off      [N_CH];
  logic [CNT_W:0]     w_hnum_inc [N_CH];
  logic [CNT_W:0]     w_half_tot;
  logic               w_last_fin;
  logic               w_restart;
  logic               w_advance;
  logic               w_accept;
  logic [T_W-1:0]     w_cyc;

  logic [N_CH-1:0]    w_run_n;
  logic [N_CH-1:0]    w_fin_n;
  logic [N_CH-1:0]    w_sig_n;
  logic [DIV_W-1:0]   w_hcnt_n [N_CH];
  logic [CNT_W:0]     w_hnum_n [N_CH];

  assign sig_out     = r_sig;
  assign busy        = r_busy;
  assign done        = r_done;
  assign burst_count = r_count;

  // Per-channel start offsets and half-period increments
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_off[g]      = T_W'(g) * T_W'(r_stg);
    assign w_hnum_inc[g] = r_hnum[g] + 1'b1;
  end

  assign w_half_tot = {r_bl, 1'b0};
  assign w_accept   = start && !stop && (half_period != '0) && (burst_len != '0);

  // The last channel finishing its final low half ends the burst.
  assign w_last_fin = r_run[N_CH-1] && (r_hcnt[N_CH-1] == r_hp) &&
                      (w_hnum_inc[N_CH-1] == w_half_tot);

  // A fresh burst begins either straight out of BURST (gap 0) or at gap end.
  assign w_restart = ((r_state == ST_BURST) && w_last_fin && r_mode && (r_gap == '0)) ||
                     ((r_state == ST_GAP) && (r_gap_cnt == r_gap));
  assign w_advance = (r_state == ST_BURST) || w_restart;
  assign w_cyc     = w_restart ? T_W'(1) : r_t;

  // Next-state of every channel's waveform for the cycle being produced
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_run_n = '0;
    w_fin_n = '0;
    w_sig_n = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_hcnt_n[k] = r_hcnt[k];
      w_hnum_n[k] = r_hnum[k];
      w_run_n[k]  = w_restart ? 1'b0 : r_run[k];
      w_fin_n[k]  = w_restart ? 1'b0 : r_fin[k];
      w_sig_n[k]  = w_restart ? 1'b0 : r_sig[k];
      if (w_advance) begin
        if (w_run_n[k]) begin
          if (r_hcnt[k] == r_hp) begin
            w_hcnt_n[k] = DIV_W'(1);
            w_hnum_n[k] = w_hnum_inc[k];
            if (w_hnum_inc[k] == w_half_tot) begin
              w_run_n[k] = 1'b0;
              w_fin_n[k] = 1'b1;
              w_sig_n[k] = 1'b0;
            end else begin
              w_sig_n[k] = ~r_sig[k];
            end
          end else begin
            w_hcnt_n[k] = r_hcnt[k] + 1'b1;
          end
        end else if (!w_fin_n[k] && (w_cyc == w_off[k] + T_W'(1))) begin
          w_run_n[k]  = 1'b1;
          w_sig_n[k]  = 1'b1;
          w_hcnt_n[k] = DIV_W'(1);
          w_hnum_n[k] = '0;
        end
      end
    end
  end

  // Sequencer FSM with registered outputs and channel state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= 1'b0;
      r_hp      <= '0;
      r_bl      <= '0;
      r_gap     <= '0;
      r_stg     <= '0;
      r_t       <= '0;
      r_gap_cnt <= '0;
      r_run     <= '0;
      r_fin     <= '0;
      r_sig     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      // NOTE: the per-channel counter arrays are small flop banks, not RAM,
      // so clearing them in reset is legal and keeps restarts deterministic.
      for (int k = 0; k < N_CH; k++) begin
        r_hcnt[k] <= '0;
        r_hnum[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_state <= ST_BURST;
            r_mode  <= mode;
            r_hp    <= half_period;
            r_bl    <= burst_len;
            r_gap   <= gap_len;
            r_stg   <= stagger;
            r_t     <= T_W'(1);
            r_run   <= '0;
            r_fin   <= '0;
            r_sig   <= '0;
            r_count <= '0;
          end
        end

        ST_BURST, ST_GAP: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_run   <= '0;
            r_fin   <= '0;
            r_sig   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_run  <= w_run_n;
            r_fin  <= w_fin_n;
            r_sig  <= w_sig_n;
            r_busy <= 1'b1;
            for (int k = 0; k < N_CH; k++) begin
              r_hcnt[k] <= w_hcnt_n[k];
              r_hnum[k] <= w_hnum_n[k];
            end
            if (r_state == ST_BURST) begin
              r_t <= w_cyc + T_W'(1);
              if (w_last_fin) begin
                r_count <= r_count + 1'b1;
                if (!r_mode) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else if (r_gap != '0) begin
                  r_state   <= ST_GAP;
                  r_gap_cnt <= CNT_W'(1);
                end
              end
            end else if (w_restart) begin
              r_state <= ST_BURST;
              r_t     <= w_cyc + T_W'(1);
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/acoustic_burst_gen.md
ACOUSTIC_BURST_GEN -- requirements
Module: acoustic_burst_gen

Interface
REQ-001 Parameter N_CH, default 4: number of transducer output channels (1..16).
REQ-002 Parameter DIV_W, default 16: width of the carrier half-period field.
REQ-003 Parameter CNT_W, default 16: width of the burst-length, gap, stagger and burst-count fields.
REQ-004 clk  in  1  system clock; the only clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a burst sequence; sampled only in IDLE.
REQ-007 stop  in  1  abort any sequence in progress.
REQ-008 mode  in  1  0 = single-shot, 1 = continuous (repeat after gap).
REQ-009 half_period  in  DIV_W  carrier half-period, in clk cycles.
REQ-010 burst_len  in  CNT_W  carrier cycles per channel per burst.
REQ-011 gap_len  in  CNT_W  idle clk cycles between bursts in continuous mode.
REQ-012 stagger  in  CNT_W  start offset, in clk cycles, between consecutive channels.
REQ-013 sig_out  out  N_CH  carrier outputs, one bit per channel, registered.
REQ-014 busy  out  1  high while a sequence is active.
REQ-015 done  out  1  one-cycle pulse when a single-shot sequence completes.
REQ-016 burst_count  out  CNT_W  completed bursts since the last accepted start; wraps modulo 2^CNT_W.

Function
REQ-017 States: IDLE, BURST, GAP.
REQ-018 IDLE->BURST when start=1, stop=0, half_period!=0 and burst_len!=0 at the sampling edge (E0); otherwise start is ignored.
REQ-019 At acceptance, mode, half_period, burst_len, gap_len and stagger are latched; later input changes have no effect until the next acceptance.
REQ-020 Acceptance clears burst_count to 0.
REQ-021 Define cycle n as the cycle following the n-th rising edge after E0. Channel k (0..N_CH-1) drives its first high at cycle 1 + k*stagger.
REQ-022 Each channel, once started, emits burst_len periods of half_period cycles high followed by half_period cycles low, then holds 0.
REQ-023 A channel not yet started, or one that has finished, drives 0.
REQ-024 BURST ends after the last low cycle of channel N_CH-1, i.e. after cycle (N_CH-1)*stagger + 2*half_period*burst_len; burst_count increments by 1 at that edge.
REQ-025 Single-shot: BURST->IDLE at burst end; busy=0 and done=1 for exactly one cycle, in the first cycle after the last low cycle.
REQ-026 Continuous: BURST->GAP for gap_len cycles with all sig_out=0, then the next burst restarts the stagger schedule from its own cycle 1. gap_len=0 goes directly from BURST to the next burst with no idle cycle; done is never pulsed.
REQ-027 busy=1 from cycle 1 through the last cycle of BURST/GAP; busy=0 in IDLE.
REQ-028 stop=1 in BURST or GAP: the next cycle has all sig_out=0, busy=0 and done=0, and the state is IDLE; burst_count holds its value.
REQ-029 stop and start asserted together in IDLE: stop wins and start is ignored.
REQ-030 start while busy is ignored, including any change to the configuration inputs.
REQ-031 stagger=0: all channels switch identically.
REQ-032 The internal time and offset counters are sized so that (N_CH-1)*stagger cannot overflow, using an extra 4 bits over CNT_W.

Reset
REQ-033 rst_n=0 immediately (asynchronously) forces sig_out=0, busy=0, done=0, burst_count=0 and state IDLE, and clears all latched configuration and counters.
REQ-034 Reset deassertion mid-sequence does not resume the sequence; the block waits in IDLE for a new start.

Verification (N_CH=4)
REQ-035 Single-shot, hp=2, bl=3, stagger=0: start at E0 -> all sig_out = 1100 repeated 3 times over cycles 1-12; busy=1 for cycles 1-12; done=1 in cycle 13 only; burst_count=1.
REQ-036 Single-shot, hp=2, bl=3, stagger=3 -> channel rises at cycles 1, 4, 7, 10; channel 3 last high at cycle 19; done=1 in cycle 22.
REQ-037 Continuous, hp=2, bl=3, stagger=0, gap=5 -> sig_out=0 in cycles 13-17; second rise at cycle 18; burst_count=1 from cycle 13 and 2 from cycle 30; no done pulse.
REQ-038 stop asserted at the edge ending cycle 5 of the REQ-035 setup -> cycle 6 has sig_out=0000, busy=0, done=0, and a later start is accepted.
REQ-039 Ignored starts: start with hp=0, start with bl=0, and start with hp=5 while busy -> busy unchanged and the running waveform unchanged.
REQ-040 rst_n pulsed low mid-burst, between clock edges -> sig_out=0000 and busy=0 before the next edge; outputs stay idle after release.
